// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT stage controller.
package fft_pkg;

   localparam int LANES    = 16;
   localparam int NVEC_DEF = 32;
   localparam int NSTG_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Vector handshake and per-stage control bundle between the frame source and the stage controller.
interface fft_stage_ctrl_if #(
   parameter int NVEC = fft_pkg::NVEC_DEF,
   parameter int NSTG = fft_pkg::NSTG_DEF,
   parameter int IW   = $clog2(NVEC)
);
   logic                     in_valid;
   logic                     frame_start;
   logic                     in_ready;
   logic [NSTG-1:0]          mul_en;
   logic [NSTG-1:0][IW-1:0]  vec_idx;
   logic                     out_valid;
   logic                     frame_done;
   logic                     busy;
   logic                     err_sync;

   modport master (
      output in_valid, frame_start,
      input  in_ready, mul_en, vec_idx, out_valid, frame_done, busy, err_sync
   );

   modport slave (
      input  in_valid, frame_start,
      output in_ready, mul_en, vec_idx, out_valid, frame_done, busy, err_sync
   );
endinterface

// File: rtl/fft_vld_pipe.sv
// Shift register carrying valid, vector index and last-of-frame flag through NSTG stages.
// One stage per cycle, never stalls; idle stages keep their previous index and flag.
module fft_vld_pipe #(
   parameter int NSTG = 3,
   parameter int IW   = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_vld_i,
   input  logic [IW-1:0]           in_idx_i,
   input  logic                    in_last_i,
   output logic [NSTG-1:0]         v_o,
   output logic [NSTG-1:0][IW-1:0] idx_o,
   output logic                    last_o
);

   logic [NSTG-1:0]         v_q;
   logic [NSTG-1:0][IW-1:0] idx_q;
   logic [NSTG-1:0]         last_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q    <= '0;
         idx_q  <= '0;
         last_q <= '0;
      end else begin
         v_q[0] <= in_vld_i;
         if (in_vld_i) begin
            idx_q[0]  <= in_idx_i;
            last_q[0] <= in_last_i;
         end
         // Index and flag only advance behind a real vector, so bubbles leave them untouched.
         for (int s = 1; s < NSTG; s++) begin
            v_q[s] <= v_q[s-1];
            if (v_q[s-1]) begin
               idx_q[s]  <= idx_q[s-1];
               last_q[s] <= last_q[s-1];
            end
         end
      end
   end

   assign v_o    = v_q;
   assign idx_o  = idx_q;
   assign last_o = last_q[NSTG-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Frame sequencer for NSTG twiddle/butterfly stages: vector accepted in cycle t reaches the last stage in t+NSTG.
// in_ready drops only during the NSTG-cycle flush after the last vector of a frame.
module fft_stage_ctrl
   import fft_pkg::*;
#(
   parameter int NVEC = NVEC_DEF,
   parameter int NSTG = NSTG_DEF,
   parameter int IW   = $clog2(NVEC)
) (
   input  logic                 clk,
   input  logic                 rst,
   fft_stage_ctrl_if.slave      bus
);

   localparam logic [IW-1:0] LAST_IDX   = IW'(NVEC - 1);
   localparam logic [3:0]    FLUSH_LAST = 4'(NSTG - 1);

   state_e                  state_q, state_d;
   logic [IW-1:0]           vec_cnt_q, vec_cnt_d;
   logic [3:0]              flush_cnt_q, flush_cnt_d;
   logic                    accept;
   logic                    pipe_vld;
   logic [IW-1:0]           pipe_idx;
   logic                    pipe_last;
   logic [NSTG-1:0]         stg_v;
   logic [NSTG-1:0][IW-1:0] stg_idx;
   logic                    stg_last;

   assign bus.in_ready = !rst && (state_q != FLUSH);
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         vec_cnt_q   <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         vec_cnt_q   <= vec_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      vec_cnt_d    = vec_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      pipe_vld     = 1'b0;
      pipe_idx     = vec_cnt_q;
      pipe_last    = 1'b0;
      bus.err_sync = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.frame_start) begin
                  state_d   = RUN;
                  vec_cnt_d = IW'(1);
                  pipe_vld  = 1'b1;
                  pipe_idx  = '0;
               end else begin
                  bus.err_sync = 1'b1;
               end
            end
         end
         RUN: begin
            if (accept) begin
               // A stray frame_start mid-frame is flagged but the vector still counts as data.
               pipe_vld     = 1'b1;
               bus.err_sync = bus.frame_start;
               if (vec_cnt_q == LAST_IDX) begin
                  pipe_last   = 1'b1;
                  state_d     = FLUSH;
                  vec_cnt_d   = '0;
                  flush_cnt_d = '0;
               end else begin
                  vec_cnt_d = vec_cnt_q + 1'b1;
               end
            end
         end
         FLUSH: begin
            if (flush_cnt_q == FLUSH_LAST) begin
               state_d = IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   fft_vld_pipe #(
      .NSTG (NSTG),
      .IW   (IW)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_vld_i  (pipe_vld),
      .in_idx_i  (pipe_idx),
      .in_last_i (pipe_last),
      .v_o       (stg_v),
      .idx_o     (stg_idx),
      .last_o    (stg_last)
   );

   assign bus.mul_en     = rst ? '0 : stg_v;
   assign bus.vec_idx    = stg_idx;
   assign bus.out_valid  = !rst && stg_v[NSTG-1];
   assign bus.frame_done = bus.out_valid && (stg_idx[NSTG-1] == LAST_IDX) && stg_last;
   assign bus.busy       = !rst && (state_q != IDLE);

endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 Parameter NVEC, default 32: 16-lane vectors per FFT frame, range 2..256.
REQ-002 Parameter NSTG, default 3: registered twiddle/butterfly stages sequenced, range 1..8.
REQ-003 Parameter IW, default $clog2(NVEC): width of the vector index.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 in_valid  in  1  a 16-lane input vector is present this cycle.
REQ-007 frame_start  in  1  qualifies in_valid: vector is index 0 of a new frame.
REQ-008 in_ready  out  1  controller accepts a vector this cycle.
REQ-009 mul_en  out  NSTG  per-stage enable; bit s drives stage s multiplier enable.
REQ-010 vec_idx  out  NSTG x IW  vector index currently held at stage s (twiddle select).
REQ-011 out_valid  out  1  a vector leaves the last stage this cycle.
REQ-012 frame_done  out  1  one-cycle pulse with the last vector of a frame at the output.
REQ-013 busy  out  1  state is not IDLE.
REQ-014 err_sync  out  1  one-cycle pulse on a framing violation.

Function
REQ-015 Accept = in_valid && in_ready; only accepted vectors enter the pipeline.
REQ-016 FSM states IDLE, RUN, FLUSH; in_ready = 1 in IDLE and RUN, 0 in FLUSH.
REQ-017 IDLE: accept with frame_start=1 -> RUN, vec_cnt <= 1; accept with frame_start=0 -> discarded, err_sync pulse, stay IDLE.
REQ-018 RUN: each accept increments vec_cnt; in_valid=0 inserts a bubble, vec_cnt holds, no timeout.
REQ-019 RUN: accept with frame_start=1 -> err_sync pulse; vector treated as ordinary data, no resync.
REQ-020 RUN: accept of vector NVEC-1 -> FLUSH, vec_cnt <= 0.
REQ-021 FLUSH: flush_cnt counts NSTG-1 cycles after entry, then -> IDLE; NSTG=1 gives one FLUSH cycle.
REQ-022 Valid pipeline v[0..NSTG-1]: v[0] <= accept; v[s] <= v[s-1]; mul_en[s] = v[s].
REQ-023 Index pipeline moves in lockstep with v; vec_idx[0] <= accepted index; bubbles keep vec_idx unchanged.
REQ-024 Latency: vector accepted at edge t -> mul_en[0] high in cycle t+1, out_valid high in cycle t+NSTG.
REQ-025 out_valid = v[NSTG-1]; frame_done = out_valid && vec_idx[NSTG-1] == NVEC-1 && last flag set.
REQ-026 Last flag travels with the data in the pipeline, so a back-to-back new frame never masks frame_done.
REQ-027 FLUSH exit coincides with frame_done; the new frame_start is accepted in the following cycle.
REQ-028 Index arithmetic is unsigned IW-bit and never wraps within a frame; vec_cnt saturates at NVEC-1.

Reset
REQ-029 rst=1 at an edge: state IDLE, vec_cnt=0, flush_cnt=0, v=0, vec_idx=0, last flags=0.
REQ-030 During reset cycles: mul_en=0, out_valid=0, frame_done=0, err_sync=0, busy=0, in_ready=0.
REQ-031 rst mid-frame discards all in-flight vectors; no frame_done is emitted for the aborted frame.
REQ-032 in_ready returns to 1 in the first cycle after rst deasserts.

Structure
REQ-033 Shared package fft_pkg holds the state enum (IDLE/RUN/FLUSH), LANES=16, and default NVEC/NSTG.
REQ-034 Sub-module fft_vld_pipe (parameterized shift register for valid, index and last bits) holds REQ-022/023.
REQ-035 The FSM and counters stay in fft_stage_ctrl; no multipliers or data lanes inside this block.

Verification (NVEC=32, NSTG=3)
REQ-036 32 back-to-back accepts starting with frame_start -> out_valid cycles 3..34, frame_done only in cycle 34, busy high 1..34.
REQ-037 in_valid low every other cycle -> vec_idx[2] sequence 0..31 unbroken, frame_done with index 31, in_ready never drops in RUN.
REQ-038 in_valid=1 with frame_start=0 in IDLE -> err_sync pulse, no mul_en, state IDLE.
REQ-039 Second frame_start raised the cycle after FLUSH exit -> accepted, frame 2 frame_done exactly 32 accepts + 3 cycles later.
REQ-040 rst asserted after vector 10 -> all outputs 0 next cycle, no frame_done, in_ready=1 one cycle after release.
REQ-041 frame_start at vector 5 mid-RUN -> err_sync single pulse, frame still ends at vector 31 with frame_done.
